ifetch_responder: RTL and testbench

IFETCH_RESPONDER -- requirements
Module: ifetch_responder

---
 rtl/ifetch_responder.sv | 63 ++++++
 tb/tb_ifetch_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_responder.sv
// ifetch_responder: single-outstanding instruction fetch responder with fixed latency and preloadable word memory
module ifetch_responder #(
  parameter logic [31:0] BASE = 32'h80000000,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic [31:0] req_addr,
  output logic resp_valid,
  input  logic resp_ready,
  output logic [31:0] resp_inst,
  output logic resp_err,
  input  logic ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_idx,
  input  logic [31:0] ld_data
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [31:0] addr, off;
  logic [DEPTH_LOG2-1:0] idx;
  logic fault, sample, accept;
  logic [31:0] mem [2**DEPTH_LOG2];
  assign off = addr - BASE;
  assign idx = off[DEPTH_LOG2+1:2];
  assign fault = addr[1:0] != 2'b00 || (off >> (DEPTH_LOG2 + 2)) != 32'd0;
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign accept = req_ready && req_valid;
  assign sample = state == WAIT && cnt == 4'd0;
  // LATENCY=1 still spends one WAIT cycle at countdown 0 so resp_valid lands one edge after accept
  always_comb begin
    state_n = state;
    state_n = accept ? WAIT : state_n;
    state_n = sample ? RESP : state_n;
    state_n = (resp_valid && resp_ready) ? IDLE : state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      addr <= 32'd0;
      resp_inst <= 32'd0;
      resp_err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr <= req_addr;
        cnt <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (sample) begin
        resp_err <= fault;
        resp_inst <= fault ? 32'd0 : (ld_en && ld_idx == idx) ? ld_data : mem[idx];
      end
    end
  end
  always_ff @(posedge clk) if (ld_en) mem[ld_idx] <= ld_data;
endmodule

// File: tb/tb_ifetch_responder.sv
// tb_ifetch_responder: vector table, corner-case sequences and randomized stream against a transaction-level model
module tb_ifetch_responder;
  localparam logic [31:0] BASE = 32'h80000000;
  localparam int LAT = 2;
  logic clk = 0, rst = 1, req_valid = 0, req_ready, resp_valid, resp_ready = 0, resp_err, ld_en = 0;
  logic [31:0] req_addr = 0, resp_inst, ld_data = 0;
  logic [9:0] ld_idx = 0;
  logic [31:0] mm [1024];
  int passed = 0, total = 0;
  typedef struct {
    logic [31:0] addr;
    logic err;
    logic [31:0] inst;
    string name;
  } vec_t;
  vec_t vecs[$];

  ifetch_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_err(resp_err),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int i, logic [31:0] d);
    ld_en = 1; ld_idx = 10'(i); ld_data = d; mm[i] = d;
    step();
    ld_en = 0;
  endtask

  // Word-addressed view: aligned and inside the 4 KiB window starting at BASE
  function automatic logic [32:0] model(logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    if (a % 4 != 0 || o >= 32'd4096) return {1'b1, 32'h0};
    return {1'b0, mm[o / 4]};
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1: return BASE + 4 * $urandom_range(0, 1023);
      2: return $urandom;
      default: return BASE + $urandom_range(0, 4200);
    endcase
  endfunction

  task automatic wait_resp(string n);
    int lat = 0;
    while (!resp_valid && lat < 20) begin step(); lat++; end
    chk({n, " latency"}, 32'(lat), 32'(LAT));
  endtask

  task automatic fetch(string n, logic [31:0] a, logic e, logic [31:0] inst);
    chk({n, " ready"}, {31'b0, req_ready}, 1);
    req_valid = 1; req_addr = a;
    step();
    req_valid = 0; req_addr = $urandom;
    wait_resp(n);
    chk({n, " inst"}, resp_inst, inst);
    chk({n, " err"}, {31'b0, resp_err}, {31'b0, e});
    resp_ready = 1;
    step();
    resp_ready = 0;
    chk({n, " done"}, {31'b0, resp_valid}, 0);
  endtask

  task automatic stream(int ncyc, bit b2b);
    logic [32:0] q[$];
    logic [32:0] e;
    int last = -1;
    for (int c = 0; c < ncyc; c++) begin
      req_valid = b2b ? 1'b1 : 1'($urandom_range(0, 1));
      resp_ready = b2b ? 1'b1 : ($urandom_range(0, 3) != 0);
      req_addr = rand_addr();
      if (req_valid && req_ready) begin
        q.push_back(model(req_addr));
        if (b2b && last >= 0) chk("b2b interval", 32'(c - last), 32'(LAT + 2));
        last = c;
      end
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) chk("stream spurious resp", 1, 0);
        else begin
          e = q.pop_front();
          chk("stream inst", resp_inst, e[31:0]);
          chk("stream err", {31'b0, resp_err}, {31'b0, e[32]});
        end
      end
      step();
    end
    req_valid = 0; resp_ready = 1;
    for (int c = 0; c < 20 && q.size() != 0; c++) begin
      if (resp_valid) begin
        e = q.pop_front();
        chk("drain inst", resp_inst, e[31:0]);
        chk("drain err", {31'b0, resp_err}, {31'b0, e[32]});
      end
      step();
    end
    chk("stream queue empty", 32'(q.size()), 0);
    resp_ready = 0;
  endtask

  initial begin
    #3;
    chk("reset resp_valid", {31'b0, resp_valid}, 0);
    chk("reset resp_err", {31'b0, resp_err}, 0);
    chk("reset resp_inst", resp_inst, 0);
    for (int i = 0; i < 1024; i++) load(i, $urandom);
    rst = 0;
    step();
    chk("post-reset req_ready", {31'b0, req_ready}, 1);
    load(0, 32'h00000413);
    load(1, 32'h12345678);
    load(5, 32'hAAAA0000);
    load(1023, 32'hDEADBEEF);

    vecs.push_back('{32'h80000000, 1'b0, 32'h00000413, "word0"});
    vecs.push_back('{32'h80000004, 1'b0, 32'h12345678, "word1"});
    vecs.push_back('{32'h80000014, 1'b0, 32'hAAAA0000, "word5"});
    vecs.push_back('{32'h80000FFC, 1'b0, 32'hDEADBEEF, "last word"});
    vecs.push_back('{32'h80000002, 1'b1, 32'h0, "misaligned"});
    vecs.push_back('{32'h80000FFF, 1'b1, 32'h0, "misaligned top"});
    vecs.push_back('{32'h7FFFFFFC, 1'b1, 32'h0, "below base"});
    vecs.push_back('{32'h80001000, 1'b1, 32'h0, "past end"});
    vecs.push_back('{32'h00000000, 1'b1, 32'h0, "far below"});
    foreach (vecs[i]) fetch(vecs[i].name, vecs[i].addr, vecs[i].err, vecs[i].inst);

    req_valid = 1; req_addr = 32'h80000004;
    step();
    req_valid = 0;
    wait_resp("hold");
    for (int i = 0; i < 5; i++) begin
      req_valid = 1; req_addr = rand_addr();
      ld_en = (i == 2); ld_idx = 10'd1; ld_data = 32'h0BADF00D;
      chk("hold valid", {31'b0, resp_valid}, 1);
      chk("hold inst", resp_inst, 32'h12345678);
      chk("hold err", {31'b0, resp_err}, 0);
      chk("hold req_ready", {31'b0, req_ready}, 0);
      step();
    end
    ld_en = 0; mm[1] = 32'h0BADF00D;
    resp_ready = 1;
    step();
    resp_ready = 0;
    chk("no accept on consume", {31'b0, req_ready}, 1);
    chk("consumed valid", {31'b0, resp_valid}, 0);
    req_valid = 0;
    fetch("rewritten word1", 32'h80000004, 1'b0, 32'h0BADF00D);

    req_valid = 1; req_addr = 32'h80000014;
    step();
    req_valid = 0;
    step();
    ld_en = 1; ld_idx = 10'd5; ld_data = 32'h00100073;
    step();
    ld_en = 0; mm[5] = 32'h00100073;
    chk("write-first valid", {31'b0, resp_valid}, 1);
    chk("write-first inst", resp_inst, 32'h00100073);
    resp_ready = 1; step(); resp_ready = 0;

    req_valid = 1; req_addr = 32'h80000014;
    step();
    req_valid = 0;
    ld_en = 1; ld_idx = 10'd5; ld_data = 32'hCAFE0001;
    step();
    ld_en = 0; mm[5] = 32'hCAFE0001;
    step();
    chk("wait preload inst", resp_inst, 32'hCAFE0001);
    resp_ready = 1; step(); resp_ready = 0;

    req_valid = 1; req_addr = 32'h80000000;
    step();
    req_valid = 0;
    #2 rst = 1;
    #1;
    chk("async rst inst", resp_inst, 0);
    chk("async rst valid", {31'b0, resp_valid}, 0);
    step();
    rst = 0;
    chk("rst req_ready", {31'b0, req_ready}, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst no resp", {31'b0, resp_valid}, 0);
    end
    fetch("after rst", 32'h80000000, 1'b0, 32'h00000413);

    stream(200, 1'b1);
    stream(300, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
